wb_port_arbiter: RTL and testbench

// Shares the single register-file write port between the in-order writeback stage and a

---
 rtl/wb_port_if.sv | 26 ++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_if.sv
// Register-file write-port bundle: W-stage write, long-latency result handshake,
// arbitrated register-file write and hazard-unit feedback.
interface wb_port_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        StallReq;

    modport slave (
        input  pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        output lu_ready, rf_we, rf_rd, rf_wdata, pend_mask, StallReq
    );

    modport master (
        output pipe_we, pipe_rd, pipe_data, lu_valid, lu_rd, lu_data,
        input  lu_ready, rf_we, rf_rd, rf_wdata, pend_mask, StallReq
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: W-stage writes win, long-latency results queue
// and drain into idle cycles, with WAW squash and a starvation stall request.
module wb_port_arbiter #(
    parameter int DEPTH     = 2,
    parameter int STARV_MAX = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    wb_port_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARV_MAX + 1);

    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_live;
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    r_starv;
    logic [31:0]      r_pend;
    logic             r_stall;

    logic             w_empty, w_full, w_pipe_win, w_head_live;
    logic             w_pop, w_push, w_push_live;
    logic [DEPTH-1:0] w_live_nxt;
    logic [31:0]      w_pend_nxt;
    logic [SW-1:0]    w_starv_nxt;

    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == CW'(DEPTH));
    // rst_n gate keeps the port silent while reset is held, even with pipe_we high
    assign w_pipe_win  = rst_n && bus.pipe_we && (bus.pipe_rd != 5'd0);
    assign w_head_live = !w_empty && r_live[r_rptr];
    // a dead head leaves regardless of who owns the port; a live one only when granted
    assign w_pop       = !w_empty && (!r_live[r_rptr] || !w_pipe_win);
    assign w_push      = bus.lu_valid && !w_full;
    assign w_push_live = (bus.lu_rd != 5'd0) && !(w_pipe_win && bus.lu_rd == bus.pipe_rd);

    assign bus.lu_ready  = !w_full;
    assign bus.pend_mask = r_pend;
    assign bus.StallReq  = r_stall;

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_rd    = 5'd0;
        bus.rf_wdata = 32'd0;
        if (w_pipe_win) begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = bus.pipe_rd;
            bus.rf_wdata = bus.pipe_data;
        end else if (w_head_live) begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = r_rd[r_rptr];
            bus.rf_wdata = r_data[r_rptr];
        end
    end

    always_comb begin
        w_live_nxt = r_live;
        for (int i = 0; i < DEPTH; i++)
            if (w_pipe_win && r_rd[i] == bus.pipe_rd) w_live_nxt[i] = 1'b0;
        if (w_pop)  w_live_nxt[r_rptr] = 1'b0;
        if (w_push) w_live_nxt[r_wptr] = w_push_live;
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_live_nxt[i]) begin
                if (w_push && r_wptr == AW'(i)) w_pend_nxt[bus.lu_rd] = 1'b1;
                else                            w_pend_nxt[r_rd[i]]   = 1'b1;
            end
        end
    end

    always_comb begin
        w_starv_nxt = r_starv;
        if (w_pop || w_empty)
            w_starv_nxt = '0;
        else if (w_head_live && r_starv != SW'(STARV_MAX))
            w_starv_nxt = r_starv + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_starv <= '0;
            r_pend  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_live  <= w_live_nxt;
            r_pend  <= w_pend_nxt;
            r_starv <= w_starv_nxt;
            r_stall <= (w_starv_nxt == SW'(STARV_MAX));
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // payload needs no reset: liveness alone decides whether an entry is used
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= bus.lu_rd;
            r_data[r_wptr] <= bus.lu_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int DEPTH     = 2;
    localparam int STARV_MAX = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_if bus();
    wb_port_arbiter #(.DEPTH(DEPTH), .STARV_MAX(STARV_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct { logic [4:0] rd; logic [31:0] d; bit live; } ent_t;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.pipe_we = we; bus.pipe_rd = rd; bus.pipe_data = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.lu_valid = v; bus.lu_rd = rd; bus.lu_data = d;
    endtask

    task automatic idle();
        pipe(1'b0, 5'd0, 32'd0);
        lu(1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        #2;
        n_cmp++;
        if ({bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_hold: got we=%b rdy=%b pend=%h stall=%b exp 0/1/0/0",
                     bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq);
        end
        tick(); rst_n = 1'b1; tick();
        n_cmp++;
        if ({bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_after: got we=%b rdy=%b pend=%h stall=%b exp 0/1/0/0",
                     bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq);
        end
    endtask

    task automatic test_idle_drain();
        lu(1'b1, 5'd5, 32'hDEADBEEF); #1;
        n_cmp++;
        if ({bus.rf_we, bus.lu_ready} !== 2'b01) begin
            n_err++; $display("FAIL drain_nobypass: got we=%b rdy=%b exp 0/1", bus.rf_we, bus.lu_ready);
        end
        tick(); lu(1'b0, 5'd0, 32'd0); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask} !== {1'b1, 5'd5, 32'hDEADBEEF, 32'h20}) begin
            n_err++; $display("FAIL drain_write: got we=%b rd=%0d d=%h pend=%h exp 1/5/deadbeef/20",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL drain_clear: got we=%b pend=%h exp 0/0", bus.rf_we, bus.pend_mask);
        end
    endtask

    task automatic test_priority_full();
        pipe(1'b1, 5'd10, 32'hA0); lu(1'b1, 5'd1, 32'h101); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.lu_ready} !== {1'b1, 5'd10, 32'hA0, 1'b1}) begin
            n_err++; $display("FAIL prio_c0: got we=%b rd=%0d d=%h rdy=%b exp 1/10/a0/1",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.lu_ready);
        end
        tick(); pipe(1'b1, 5'd10, 32'hA1); lu(1'b1, 5'd2, 32'h102); #1;
        n_cmp++;
        if ({bus.rf_rd, bus.lu_ready, bus.pend_mask} !== {5'd10, 1'b1, 32'h2}) begin
            n_err++; $display("FAIL prio_c1: got rd=%0d rdy=%b pend=%h exp 10/1/2",
                              bus.rf_rd, bus.lu_ready, bus.pend_mask);
        end
        tick(); pipe(1'b1, 5'd10, 32'hA2); lu(1'b1, 5'd3, 32'h103); #1;
        n_cmp++;
        if ({bus.rf_rd, bus.rf_wdata, bus.lu_ready, bus.pend_mask} !== {5'd10, 32'hA2, 1'b0, 32'h6}) begin
            n_err++; $display("FAIL prio_full: got rd=%0d d=%h rdy=%b pend=%h exp 10/a2/0/6",
                              bus.rf_rd, bus.rf_wdata, bus.lu_ready, bus.pend_mask);
        end
        tick(); idle(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.lu_ready} !== {1'b1, 5'd1, 32'h101, 1'b0}) begin
            n_err++; $display("FAIL prio_drain1: got we=%b rd=%0d d=%h rdy=%b exp 1/1/101/0",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.lu_ready);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask} !== {1'b1, 5'd2, 32'h102, 32'h4}) begin
            n_err++; $display("FAIL prio_drain2: got we=%b rd=%0d d=%h pend=%h exp 1/2/102/4",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask, bus.lu_ready} !== {1'b0, 32'd0, 1'b1}) begin
            n_err++; $display("FAIL prio_empty: got we=%b pend=%h rdy=%b exp 0/0/1 (x3 must not appear)",
                              bus.rf_we, bus.pend_mask, bus.lu_ready);
        end
    endtask

    task automatic test_waw();
        pipe(1'b1, 5'd20, 32'hAA); lu(1'b1, 5'd7, 32'h11);
        tick(); lu(1'b0, 5'd0, 32'd0); pipe(1'b1, 5'd7, 32'h22); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask} !== {1'b1, 5'd7, 32'h22, 32'h80}) begin
            n_err++; $display("FAIL waw_pipe: got we=%b rd=%0d d=%h pend=%h exp 1/7/22/80",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.pend_mask);
        end
        tick(); idle(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL waw_deadpop: got we=%b pend=%h exp 0/0", bus.rf_we, bus.pend_mask);
        end
        tick(); pipe(1'b1, 5'd8, 32'h33); lu(1'b1, 5'd8, 32'h44); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd8, 32'h33}) begin
            n_err++; $display("FAIL waw_same_pipe: got we=%b rd=%0d d=%h exp 1/8/33",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick(); idle(); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL waw_same_dead: got we=%b pend=%h exp 0/0", bus.rf_we, bus.pend_mask);
        end
        tick();
    endtask

    task automatic test_starvation();
        bit early;
        early = 1'b0;
        pipe(1'b1, 5'd3, 32'h33); lu(1'b1, 5'd9, 32'h99);
        tick(); lu(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= STARV_MAX; k++) begin
            #1;
            if (bus.StallReq !== 1'b0 || bus.rf_rd !== 5'd3) early = 1'b1;
            tick();
        end
        n_cmp++;
        if (early) begin
            n_err++; $display("FAIL starv_early: got stall/port change within %0d blocked cycles exp none", STARV_MAX);
        end
        #1;
        n_cmp++;
        if ({bus.StallReq, bus.rf_rd, bus.pend_mask} !== {1'b1, 5'd3, 32'h200}) begin
            n_err++; $display("FAIL starv_assert: got stall=%b rd=%0d pend=%h exp 1/3/200",
                              bus.StallReq, bus.rf_rd, bus.pend_mask);
        end
        tick(); pipe(1'b0, 5'd0, 32'd0); #1;
        n_cmp++;
        if ({bus.StallReq, bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 1'b1, 5'd9, 32'h99}) begin
            n_err++; $display("FAIL starv_drain: got stall=%b we=%b rd=%0d d=%h exp 1/1/9/99",
                              bus.StallReq, bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick(); #1;
        n_cmp++;
        if ({bus.StallReq, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL starv_release: got stall=%b pend=%h exp 0/0", bus.StallReq, bus.pend_mask);
        end
    endtask

    task automatic test_x0();
        pipe(1'b1, 5'd12, 32'hC); lu(1'b1, 5'd4, 32'h44);
        tick(); lu(1'b0, 5'd0, 32'd0); pipe(1'b1, 5'd0, 32'hBAD); #1;
        n_cmp++;
        if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin
            n_err++; $display("FAIL x0_pipe: got we=%b rd=%0d d=%h exp 1/4/44",
                              bus.rf_we, bus.rf_rd, bus.rf_wdata);
        end
        tick(); pipe(1'b0, 5'd0, 32'd0); lu(1'b1, 5'd0, 32'h55); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL x0_push: got we=%b pend=%h exp 0/0", bus.rf_we, bus.pend_mask);
        end
        tick(); lu(1'b0, 5'd0, 32'd0); #1;
        n_cmp++;
        if ({bus.rf_we, bus.pend_mask} !== {1'b0, 32'd0}) begin
            n_err++; $display("FAIL x0_deadhead: got we=%b pend=%h exp 0/0", bus.rf_we, bus.pend_mask);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit leak;
        leak = 1'b0;
        pipe(1'b1, 5'd15, 32'hF); lu(1'b1, 5'd6, 32'h66);
        tick(); lu(1'b1, 5'd11, 32'hBB);
        tick(); lu(1'b0, 5'd0, 32'd0); #1;
        n_cmp++;
        if ({bus.lu_ready, bus.pend_mask} !== {1'b0, 32'h840}) begin
            n_err++; $display("FAIL rstmid_fill: got rdy=%b pend=%h exp 0/840", bus.lu_ready, bus.pend_mask);
        end
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_err++; $display("FAIL rstmid_hold: got we=%b rdy=%b pend=%h stall=%b exp 0/1/0/0",
                              bus.rf_we, bus.lu_ready, bus.pend_mask, bus.StallReq);
        end
        idle();
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.rf_we !== 1'b0 || bus.pend_mask !== 32'd0 || bus.lu_ready !== 1'b1) leak = 1'b1;
            tick();
        end
        n_cmp++;
        if (leak) begin
            n_err++; $display("FAIL rstmid_leak: got queued write or pending bits after reset exp none");
        end
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   starv;
        bit   stall, pw, rdy, emp, popped;
        logic        x_we;
        logic [4:0]  x_rd;
        logic [31:0] x_d, x_pend;
        int   stall_seen;
        starv = 0; stall = 1'b0; stall_seen = 0;
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            pipe(($urandom_range(0, 99) < (((c / 150) % 2 == 1) ? 96 : 50)),
                 5'($urandom_range(0, 7)), $urandom);
            lu(($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
            #1;
            pw  = bus.pipe_we && bus.pipe_rd != 5'd0;
            emp = (q.size() == 0);
            rdy = (q.size() < DEPTH);
            x_we = 1'b0; x_rd = 5'd0; x_d = 32'd0;
            if (pw) begin
                x_we = 1'b1; x_rd = bus.pipe_rd; x_d = bus.pipe_data;
            end else if (!emp && q[0].live) begin
                x_we = 1'b1; x_rd = q[0].rd; x_d = q[0].d;
            end
            x_pend = 32'd0;
            foreach (q[i]) if (q[i].live) x_pend[q[i].rd] = 1'b1;
            n_cmp++;
            if ({bus.rf_we, bus.rf_rd, bus.rf_wdata} !== {x_we, x_rd, x_d}) begin
                n_err++; $display("FAIL rand_port c%0d: got %b/%0d/%h exp %b/%0d/%h",
                                  c, bus.rf_we, bus.rf_rd, bus.rf_wdata, x_we, x_rd, x_d);
            end
            n_cmp++;
            if (bus.lu_ready !== rdy) begin
                n_err++; $display("FAIL rand_ready c%0d: got %b exp %b", c, bus.lu_ready, rdy);
            end
            n_cmp++;
            if (bus.pend_mask !== x_pend) begin
                n_err++; $display("FAIL rand_pend c%0d: got %h exp %h", c, bus.pend_mask, x_pend);
            end
            n_cmp++;
            if (bus.StallReq !== stall) begin
                n_err++; $display("FAIL rand_stall c%0d: got %b exp %b", c, bus.StallReq, stall);
            end
            if (stall) stall_seen++;
            popped = !emp && (!q[0].live || !pw);
            if (popped || emp) starv = 0;
            else if (q[0].live && starv < STARV_MAX) starv++;
            stall = (starv == STARV_MAX);
            if (popped) void'(q.pop_front());
            if (pw) foreach (q[i]) if (q[i].rd == bus.pipe_rd) q[i].live = 1'b0;
            if (bus.lu_valid && rdy) begin
                e.rd = bus.lu_rd; e.d = bus.lu_data;
                e.live = (bus.lu_rd != 5'd0) && !(pw && bus.lu_rd == bus.pipe_rd);
                q.push_back(e);
            end
            tick();
        end
        n_cmp++;
        if (stall_seen == 0) begin
            n_err++; $display("FAIL rand_stall_cov: got 0 stall cycles exp >0");
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_idle_drain();
        test_priority_full();
        test_waw();
        test_starvation();
        test_x0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
